// File: rtl/psum_deskew_accumulator.sv
// Re-aligns skewed PE-row partial sums into one vector, accumulates it across K-tiles
// in an on-chip bank, and queues finished vectors in a valid/ready output FIFO.
module psum_deskew_accumulator #(
  parameter int unsigned PARTIAL_SUM_BW = 19,
  parameter int unsigned ACC_BW         = 24,
  parameter int unsigned MATRIX_SIZE    = 8,
  parameter int unsigned ACC_DEPTH      = 16,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0]   psum_in,
  input  logic                                    first_tile,
  input  logic                                    last_tile,
  input  logic [$clog2(ACC_DEPTH)-1:0]            row_count,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [MATRIX_SIZE*ACC_BW-1:0]           out_data,
  output logic                                    overflow
);

  localparam int unsigned PW   = PARTIAL_SUM_BW;
  localparam int unsigned AB   = ACC_BW;
  localparam int unsigned M    = MATRIX_SIZE;
  localparam int unsigned TD   = MATRIX_SIZE - 1;
  localparam int unsigned AW   = $clog2(ACC_DEPTH);
  localparam int unsigned FPW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCCW = $clog2(FIFO_DEPTH + MATRIX_SIZE) + 1;
  localparam int unsigned OW   = MATRIX_SIZE * ACC_BW;

  logic [PW-1:0] aligned_c [M];

  // Lane r is delayed M-1-r cycles so every lane lines up with the last row.
  for (genvar r = 0; r < M; r++) begin : g_lane
    localparam int unsigned DLY = M - 1 - r;
    logic [PW-1:0] lane_in;
    assign lane_in = psum_in[(M-1-r)*PW +: PW];
    if (DLY == 0) begin : g_direct
      assign aligned_c[r] = lane_in;
    end else begin : g_delay
      logic [PW-1:0] dly_q [DLY];
      logic [PW-1:0] dly_d [DLY];
      always_comb begin
        dly_d[0] = lane_in;
        for (int unsigned i = 1; i < DLY; i++) dly_d[i] = dly_q[i-1];
      end
      always_ff @(posedge clk) begin
        if (rst) dly_q <= '{default: '0};
        else     dly_q <= dly_d;
      end
      assign aligned_c[r] = dly_q[DLY-1];
    end
  end

  logic [TD-1:0]   vld_q, vld_d, first_q, first_d, last_q, last_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [FPW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            out_valid_q, out_valid_d, overflow_q, overflow_d;
  logic [OW-1:0]   out_data_q, out_data_d;
  logic [AB-1:0]   bank_q [ACC_DEPTH][M];
  logic [OW-1:0]   fifo_q [FIFO_DEPTH];

  logic            in_acc_c, al_vld_c, al_first_c, al_last_c;
  logic [OCCW-1:0] pending_c, occ_c;
  logic [AB-1:0]   sum_c [M];
  logic            sat_c;
  logic [OW-1:0]   push_data_c;
  logic            push_c, push_en_c, pop_c;
  logic [AB:0]     ext_c, old_c, raw_c;

  // Credit check counts last-tagged vectors still in flight so pushes never hit a full FIFO.
  always_comb begin
    pending_c = '0;
    for (int unsigned i = 0; i < TD; i++) pending_c = pending_c + OCCW'(vld_q[i] & last_q[i]);
    occ_c    = OCCW'(count_q) + pending_c;
    in_ready = !rst && (occ_c < OCCW'(FIFO_DEPTH - MATRIX_SIZE));
    in_acc_c = in_valid && in_ready;
  end

  always_comb begin
    vld_d      = vld_q;
    first_d    = first_q;
    last_d     = last_q;
    vld_d[0]   = in_acc_c;
    first_d[0] = first_tile;
    last_d[0]  = last_tile;
    for (int unsigned i = 1; i < TD; i++) begin
      vld_d[i]   = vld_q[i-1];
      first_d[i] = first_q[i-1];
      last_d[i]  = last_q[i-1];
    end
    al_vld_c   = vld_q[TD-1];
    al_first_c = first_q[TD-1];
    al_last_c  = last_q[TD-1];
  end

  // Per-lane sign-extend, add to the bank entry and clamp to the ACC_BW range.
  always_comb begin
    sat_c       = 1'b0;
    push_data_c = '0;
    sum_c       = '{default: '0};
    ext_c       = '0;
    old_c       = '0;
    raw_c       = '0;
    for (int unsigned r = 0; r < M; r++) begin
      ext_c = {{(AB+1-PW){aligned_c[r][PW-1]}}, aligned_c[r]};
      old_c = {bank_q[addr_q][r][AB-1], bank_q[addr_q][r]};
      raw_c = old_c + ext_c;
      if (al_first_c) begin
        sum_c[r] = ext_c[AB-1:0];
      end else if (raw_c[AB] != raw_c[AB-1]) begin
        sum_c[r] = raw_c[AB] ? {1'b1, {(AB-1){1'b0}}} : {1'b0, {(AB-1){1'b1}}};
        sat_c    = 1'b1;
      end else begin
        sum_c[r] = raw_c[AB-1:0];
      end
      push_data_c[(M-1-r)*AB +: AB] = sum_c[r];
    end
  end

  always_comb begin
    push_c     = al_vld_c && al_last_c;
    pop_c      = out_valid_q && out_ready;
    push_en_c  = push_c && ((count_q != CNTW'(FIFO_DEPTH)) || pop_c);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    addr_d     = addr_q;
    overflow_d = overflow_q | (al_vld_c & sat_c);
    if (al_vld_c) addr_d = (addr_q == row_count) ? '0 : addr_q + 1'b1;
    if (push_en_c) wr_ptr_d = (wr_ptr_q == FPW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop_c)     rd_ptr_d = (rd_ptr_q == FPW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push_en_c, pop_c})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    out_valid_d = (count_d != '0);
    // Head register bypasses the memory when the new head is the entry written this edge.
    if (count_d == '0)                               out_data_d = out_data_q;
    else if (push_en_c && (wr_ptr_q == rd_ptr_d))    out_data_d = push_data_c;
    else                                             out_data_d = fifo_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      first_q     <= '0;
      last_q      <= '0;
      addr_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      first_q     <= first_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && al_vld_c)  bank_q[addr_q]   <= sum_c;
    if (!rst && push_en_c) fifo_q[wr_ptr_q] <= push_data_c;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_psum_deskew_accumulator.sv
// Scoreboard bench: vector-level accumulate model feeds an expected queue, a negedge
// monitor checks every presented output head against it.
module tb_psum_deskew_accumulator;

  localparam int unsigned PW = 19;
  localparam int unsigned AB = 24;
  localparam int unsigned M  = 8;
  localparam int unsigned AD = 16;
  localparam int unsigned FD = 16;
  localparam int unsigned AW = 4;
  localparam longint ACC_MAX = (longint'(1) << (AB - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (AB - 1));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, in_valid, in_ready, first_tile, last_tile;
  logic            out_valid, out_ready, overflow;
  logic [M*PW-1:0] psum_in;
  logic [AW-1:0]   row_count;
  logic [M*AB-1:0] out_data;

  psum_deskew_accumulator #(
    .PARTIAL_SUM_BW(PW), .ACC_BW(AB), .MATRIX_SIZE(M), .ACC_DEPTH(AD), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .psum_in(psum_in),
    .first_tile(first_tile), .last_tile(last_tile), .row_count(row_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .overflow(overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state: bank contents, address, sticky overflow, expected output vectors.
  longint          bank_m [AD][M];
  int              addr_m;
  bit              ovf_m;
  logic [M*AB-1:0] exp_q [$];
  int              vin [M];
  bit              hv [M];
  int              hl [M][M];
  bit              rand_rdy;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_accept(input bit f, input bit l);
    logic [M*AB-1:0] e;
    longint s;
    e = '0;
    for (int r = 0; r < M; r++) begin
      s = f ? longint'(vin[r]) : bank_m[addr_m][r] + longint'(vin[r]);
      if (s > ACC_MAX) begin s = ACC_MAX; ovf_m = 1'b1; end
      if (s < ACC_MIN) begin s = ACC_MIN; ovf_m = 1'b1; end
      bank_m[addr_m][r] = s;
      e[(M-1-r)*AB +: AB] = AB'(s);
    end
    if (l) exp_q.push_back(e);
    addr_m = (addr_m == int'(row_count)) ? 0 : addr_m + 1;
  endtask

  // One cycle of stimulus: row r of psum_in carries lane r of the vector issued r cycles ago.
  task automatic drive(input bit want, input bit f, input bit l);
    bit acc;
    acc        = want && in_ready && !rst;
    in_valid   = want;
    first_tile = f;
    last_tile  = l;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    for (int r = M - 1; r > 0; r--) begin
      hv[r] = hv[r-1];
      for (int c = 0; c < M; c++) hl[r][c] = hl[r-1][c];
    end
    hv[0] = want;
    for (int c = 0; c < M; c++) hl[0][c] = vin[c];
    for (int r = 0; r < M; r++)
      psum_in[(M-1-r)*PW +: PW] = hv[r] ? PW'(hl[r][r]) : PW'($urandom);
    if (acc) model_accept(f, l);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit f, input bit l);
    int k;
    k = 0;
    while (!in_ready && k < 60) begin
      drive(1'b0, 1'b0, 1'b0);
      k++;
    end
    check("issue_wait_in_ready", 256'(in_ready), 256'(1));
    if (in_ready) drive(1'b1, f, l);
  endtask

  task automatic rand_vec();
    for (int c = 0; c < M; c++) vin[c] = int'($urandom_range(0, (1 << PW) - 1)) - (1 << (PW - 1));
  endtask

  task automatic const_vec(input int v);
    for (int c = 0; c < M; c++) vin[c] = v;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      drive(1'b0, 1'b0, 1'b0);
      k++;
    end
    check(name, 256'(exp_q.size()), 256'(0));
    repeat (M + 2) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    exp_q.delete();
    addr_m = 0;
    ovf_m  = 1'b0;
    for (int r = 0; r < M; r++) hv[r] = 1'b0;
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_out_data", 256'(out_data), 256'(0));
    check("rst_overflow", 256'(overflow), 256'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 256'(in_ready), 256'(1));
  endtask

  // Monitor: every presented head must match the oldest outstanding expected vector.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else begin
        check("out_data", 256'(out_data), 256'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int t0, lat, n_acc, nv, rr, kk;
    rst = 1'b1; in_valid = 1'b0; first_tile = 1'b0; last_tile = 1'b0;
    psum_in = '0; row_count = '0; out_ready = 1'b1; rand_rdy = 1'b0;
    const_vec(0);
    for (int r = 0; r < M; r++) hv[r] = 1'b0;
    do_reset();

    // Single tile, lanes 1..8, latency M from in_valid to out_valid.
    row_count = '0;
    for (int c = 0; c < M; c++) vin[c] = c + 1;
    t0 = cyc;
    issue(1'b1, 1'b1);
    t0 = cyc - 1;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b0, 1'b0);
      if (out_valid) begin lat = cyc - t0; break; end
    end
    check("first_latency", 256'(lat), 256'(M));
    drain("t1_drain");

    // Two tiles of two rows: +5 then -3 leaves 2 in every lane.
    row_count = AW'(1);
    const_vec(5);  issue(1'b1, 1'b0); issue(1'b1, 1'b0);
    const_vec(-3); issue(1'b0, 1'b1); issue(1'b0, 1'b1);
    drain("t2_drain");

    // Saturation over 40 tiles of max positive partial sums.
    row_count = '0;
    const_vec((1 << (PW - 1)) - 1);
    for (int k = 0; k < 40; k++) issue(k == 0, k == 39);
    drain("t3_drain");
    check("sat_overflow", 256'(overflow), 256'(1));
    check("sat_overflow_model", 256'(overflow), 256'(ovf_m));
    rand_vec(); issue(1'b1, 1'b1);
    drain("t3b_drain");
    check("overflow_sticky", 256'(overflow), 256'(1));

    // Backpressure: with no consumer, acceptance stops after FD-M vectors.
    do_reset();
    row_count = '0;
    out_ready = 1'b0;
    n_acc = 0;
    for (int k = 0; k < 20; k++) begin
      if (!in_ready) break;
      rand_vec();
      drive(1'b1, 1'b1, 1'b1);
      n_acc++;
    end
    check("bp_accepted", 256'(n_acc), 256'(FD - M));
    repeat (4) drive(1'b0, 1'b0, 1'b0);
    check("bp_in_ready_low", 256'(in_ready), 256'(0));
    rand_vec();
    drive(1'b1, 1'b1, 1'b1);
    out_ready = 1'b1;
    while (n_acc < 16) begin
      rand_vec();
      issue(1'b1, 1'b1);
      n_acc++;
    end
    drain("t4_drain");

    // Sustained push/pop after filling to the credit limit.
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!in_ready) break;
      rand_vec();
      drive(1'b1, 1'b1, 1'b1);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin rand_vec(); issue(1'b1, 1'b1); end
    drain("t5_drain");

    // Reset three cycles into a job discards it; the next job is clean.
    do_reset();
    row_count = '0;
    const_vec((1 << (PW - 1)) - 1);
    issue(1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    do_reset();
    nv = 0;
    repeat (15) begin
      drive(1'b0, 1'b0, 1'b0);
      if (out_valid) nv++;
    end
    check("rst_no_output", 256'(nv), 256'(0));
    check("rst_overflow_clear", 256'(overflow), 256'(0));
    rand_vec(); issue(1'b1, 1'b1);
    drain("t6_drain");

    // Randomized jobs with random consumer stalls.
    rand_rdy = 1'b1;
    for (int j = 0; j < 8; j++) begin
      rr = int'($urandom_range(0, 3));
      kk = int'($urandom_range(1, 4));
      row_count = AW'(rr);
      for (int k = 0; k < kk; k++) begin
        for (int a = 0; a <= rr; a++) begin
          rand_vec();
          issue(k == 0, k == kk - 1);
          repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b0);
        end
      end
      repeat (M) drive(1'b0, 1'b0, 1'b0);
    end
    drain("rand_drain");
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    check("final_overflow", 256'(overflow), 256'(ovf_m));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
